// File: rtl/bram_viewer.sv
// bram_viewer: parametrised block RAM with an edge-driven or auto-scanning address pointer
// and a hex seven-segment readout of the current address and its data word.
`default_nettype none

module bram_viewer #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int SCAN_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  input  logic              wren,
  input  logic              scan,
  input  logic [DATA_W-1:0] data_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic [6:0]        hex0,
  output logic [6:0]        hex1,
  output logic [6:0]        hex2,
  output logic [6:0]        hex3,
  output logic [6:0]        hex4,
  output logic [6:0]        hex5
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  // Bit order in the conditioning pipes: {scan, wren, dec, inc}
  logic [3:0]        sync1_q, sync2_q;
  logic [2:0]        prev_q, pulse_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic inc_p, dec_p, wr_p, scan_on;
  assign inc_p   = pulse_q[0];
  assign dec_p   = pulse_q[1];
  assign wr_p    = pulse_q[2];
  assign scan_on = sync2_q[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pulse_q <= '0;
    end else begin
      sync1_q <= {scan, wren, dec, inc};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q[2:0];
      pulse_q <= sync2_q[2:0] & ~prev_q;
    end
  end

  always_comb begin
    addr_d = addr_q;
    cnt_d  = '0;
    if (scan_on) begin
      if (cnt_q == CNT_LAST) begin
        addr_d = addr_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (inc_p && !dec_p) begin
      addr_d = addr_q + 1'b1;
    end else if (dec_p && !inc_p) begin
      addr_d = addr_q - 1'b1;
    end
  end

  // The array is deliberately outside the reset domain so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_p) begin
      mem[addr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      data_q <= wr_p ? data_i : mem[addr_q];
    end
  end

  assign addr_o = addr_q;
  assign data_o = data_q;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0:    seg7 = 7'h40;
      4'h1:    seg7 = 7'h79;
      4'h2:    seg7 = 7'h24;
      4'h3:    seg7 = 7'h30;
      4'h4:    seg7 = 7'h19;
      4'h5:    seg7 = 7'h12;
      4'h6:    seg7 = 7'h02;
      4'h7:    seg7 = 7'h78;
      4'h8:    seg7 = 7'h00;
      4'h9:    seg7 = 7'h10;
      4'hA:    seg7 = 7'h08;
      4'hB:    seg7 = 7'h03;
      4'hC:    seg7 = 7'h46;
      4'hD:    seg7 = 7'h21;
      4'hE:    seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  logic [6:0] dig_data [4];
  logic [6:0] dig_addr [2];

  for (genvar i = 0; i < 4; i++) begin : g_data_digit
    if (4 * i < DATA_W) begin : g_used
      localparam int HI = (4 * i + 3 < DATA_W) ? 4 * i + 3 : DATA_W - 1;
      assign dig_data[i] = seg7(4'(data_q[HI:4*i]));
    end else begin : g_blank
      assign dig_data[i] = 7'h7F;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_addr_digit
    if (4 * i < ADDR_W) begin : g_used
      localparam int HI = (4 * i + 3 < ADDR_W) ? 4 * i + 3 : ADDR_W - 1;
      assign dig_addr[i] = seg7(4'(addr_q[HI:4*i]));
    end else begin : g_blank
      assign dig_addr[i] = 7'h7F;
    end
  end

  assign hex0 = dig_data[0];
  assign hex1 = dig_data[1];
  assign hex2 = dig_data[2];
  assign hex3 = dig_data[3];
  assign hex4 = dig_addr[0];
  assign hex5 = dig_addr[1];

endmodule

`default_nettype wire

// File: tb/tb_bram_viewer.sv
// tb_bram_viewer: directed and random checks of bram_viewer in an 8x32 and a 16x256 build.
`default_nettype none

module tb_bram_viewer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, inc, dec, wren, scan;
  logic [7:0] din;
  logic [4:0] a_addr;
  logic [7:0] a_data;
  logic [6:0] a_h0, a_h1, a_h2, a_h3, a_h4, a_h5;

  logic        b_inc, b_dec, b_wren, b_scan;
  logic [15:0] b_din;
  logic [7:0]  b_addr;
  logic [15:0] b_data;
  logic [6:0]  b_h0, b_h1, b_h2, b_h3, b_h4, b_h5;

  bram_viewer #(.DATA_W(8), .ADDR_W(5), .SCAN_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .wren(wren), .scan(scan),
    .data_i(din), .addr_o(a_addr), .data_o(a_data),
    .hex0(a_h0), .hex1(a_h1), .hex2(a_h2), .hex3(a_h3), .hex4(a_h4), .hex5(a_h5)
  );

  bram_viewer #(.DATA_W(16), .ADDR_W(8), .SCAN_DIV(4)) dut_b (
    .clk(clk), .rst(rst), .inc(b_inc), .dec(b_dec), .wren(b_wren), .scan(b_scan),
    .data_i(b_din), .addr_o(b_addr), .data_o(b_data),
    .hex0(b_h0), .hex1(b_h1), .hex2(b_h2), .hex3(b_h3), .hex4(b_h4), .hex5(b_h5)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference: memory contents and pointer of the 8x32 build
  logic [7:0] m_mem [32];
  int         m_addr;

  // Lit segments per hex glyph, letters a..g map to bits 0..6 (active low)
  string SEGS [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                       "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] seg_of(input int n);
    logic [6:0] r;
    string s;
    r = 7'h7F;
    s = SEGS[n];
    for (int k = 0; k < s.len(); k++) r[int'(s[k]) - 97] = 1'b0;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_view(input string tag);
    logic [7:0] d;
    d = m_mem[m_addr];
    check({tag, "/addr"}, 32'(a_addr), 32'(m_addr));
    check({tag, "/data"}, 32'(a_data), 32'(d));
    check({tag, "/hex0"}, 32'(a_h0), 32'(seg_of(d % 16)));
    check({tag, "/hex1"}, 32'(a_h1), 32'(seg_of(d / 16)));
    check({tag, "/hex2"}, 32'(a_h2), 32'h7F);
    check({tag, "/hex3"}, 32'(a_h3), 32'h7F);
    check({tag, "/hex4"}, 32'(a_h4), 32'(seg_of(m_addr % 16)));
    check({tag, "/hex5"}, 32'(a_h5), 32'(seg_of(m_addr / 16)));
  endtask

  // Raise the chosen levels together, drop them, let the pipeline settle, update the model
  task automatic do_op(input bit i, input bit d, input bit w);
    inc = i; dec = d; wren = w;
    tick(3);
    inc = 1'b0; dec = 1'b0; wren = 1'b0;
    tick(6);
    if (w) m_mem[m_addr] = din;
    if (i && !d) m_addr = (m_addr + 1) % 32;
    else if (d && !i) m_addr = (m_addr + 31) % 32;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int chg_cyc [3];
    int chg_val [3];
    int nchg, cyc, op;
    logic [4:0] last;
    bit seen;

    rst = 1'b1; inc = 1'b0; dec = 1'b0; wren = 1'b0; scan = 1'b0; din = '0;
    b_inc = 1'b0; b_dec = 1'b0; b_wren = 1'b0; b_scan = 1'b0; b_din = '0;
    for (int k = 0; k < 32; k++) m_mem[k] = 8'h00;
    m_addr = 0;
    tick(2);

    check("rst/addr", 32'(a_addr), 0);
    check("rst/data", 32'(a_data), 0);
    check("rst/hex0", 32'(a_h0), 32'(seg_of(0)));
    check("rst/hex3", 32'(a_h3), 32'h7F);
    check("rst/hex5", 32'(a_h5), 32'(seg_of(0)));
    check("rst_b/hex3", 32'(b_h3), 32'(seg_of(0)));
    check("rst_b/hex5", 32'(b_h5), 32'(seg_of(0)));
    rst = 1'b0;
    tick(2);
    check_view("post_rst");

    for (int k = 0; k < 3; k++) do_op(1, 0, 0);
    check_view("inc3");
    check("inc3/hex4_lit", 32'(a_h4), 32'h30);

    din = 8'hA5;
    do_op(0, 0, 1);
    check_view("wr_a5");
    check("wr_a5/data_lit", 32'(a_data), 32'hA5);
    do_op(1, 0, 0);
    do_op(0, 1, 0);
    check_view("back_a5");

    for (int k = 0; k < 4; k++) do_op(0, 1, 0);
    check_view("at31");
    do_op(1, 0, 0);
    check_view("wrap_up");
    do_op(0, 1, 0);
    check_view("wrap_down");
    check("wrap_down/hex5_lit", 32'(a_h5), 32'(seg_of(1)));

    do_op(1, 1, 0);
    check_view("inc_dec");

    for (int k = 0; k < 8; k++) do_op(1, 0, 0);
    din = 8'h3C;
    do_op(1, 0, 1);
    check_view("wr_inc");
    do_op(0, 1, 0);
    check_view("wr_inc_back");

    for (int k = 0; k < 30; k++) begin
      op  = int'($urandom_range(0, 4));
      din = 8'($urandom);
      case (op)
        0: do_op(1, 0, 0);
        1: do_op(0, 1, 0);
        2: do_op(0, 0, 1);
        3: do_op(1, 1, 0);
        default: do_op($urandom_range(0, 1) == 1, 0, 1);
      endcase
      check_view("rand");
    end

    // Scan: steps every 4 cycles after the synchronised rise; inc edges are ignored
    rst = 1'b1; tick(1); rst = 1'b0; m_addr = 0;
    tick(1);
    scan = 1'b1;
    nchg = 0; cyc = 0; last = a_addr;
    for (int k = 0; k < 3; k++) begin chg_cyc[k] = -1; chg_val[k] = -1; end
    while (nchg < 3 && cyc < 60) begin
      tick(1);
      cyc++;
      if (cyc == 3) inc = 1'b1;
      if (cyc == 6) inc = 1'b0;
      if (a_addr !== last) begin
        chg_cyc[nchg] = cyc;
        chg_val[nchg] = int'(a_addr);
        nchg++;
        last = a_addr;
      end
    end
    check("scan/first_cyc", 32'(chg_cyc[0]), 6);
    check("scan/val0", 32'(chg_val[0]), 1);
    check("scan/val1", 32'(chg_val[1]), 2);
    check("scan/val2", 32'(chg_val[2]), 3);
    check("scan/gap0", 32'(chg_cyc[1] - chg_cyc[0]), 4);
    check("scan/gap1", 32'(chg_cyc[2] - chg_cyc[1]), 4);

    tick(1);
    #2;
    rst = 1'b1;
    #1;
    check("scan_rst/addr", 32'(a_addr), 0);
    check("scan_rst/hex4", 32'(a_h4), 32'(seg_of(0)));
    tick(1);
    rst = 1'b0;
    tick(1);
    check("scan_rst/data", 32'(a_data), 32'(m_mem[0]));
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick(1);
      if (a_addr !== 5'd0) seen = 1'b1;
    end
    scan = 1'b0;
    check("scan_rst/step", 32'(a_addr), 1);
    m_addr = 1;
    tick(8);
    check_view("scan_off");

    // Wide build: walk back from 0 to 8'hC4, write 16'hBEEF
    for (int k = 0; k < 60; k++) begin
      b_dec = 1'b1; tick(3); b_dec = 1'b0; tick(6);
    end
    b_din = 16'hBEEF;
    b_wren = 1'b1; tick(3); b_wren = 1'b0; tick(6);
    check("wide/addr", 32'(b_addr), 32'hC4);
    check("wide/data", 32'(b_data), 32'hBEEF);
    check("wide/hex0", 32'(b_h0), 32'(seg_of(15)));
    check("wide/hex1", 32'(b_h1), 32'(seg_of(14)));
    check("wide/hex2", 32'(b_h2), 32'(seg_of(14)));
    check("wide/hex3", 32'(b_h3), 32'(seg_of(11)));
    check("wide/hex4", 32'(b_h4), 32'(seg_of(4)));
    check("wide/hex5", 32'(b_h5), 32'(seg_of(12)));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
